// File: rtl/mac_engine_ctrl.sv
// mac_engine_ctrl: sequencer in front of mac_engine.
// Double-buffered weight bank, credit-based activation issue, in-flight tag
// pipeline matched to the engine latency, and a FWFT result FIFO.
// Optional MAC_CTRL_PERF_EN adds saturating stall/backpressure/swap counters.
module mac_engine_ctrl #(
   parameter int ENG_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          w_wr_en,
   input  logic [2:0]    w_wr_row,
   input  logic [63:0]   w_wr_data,
   input  logic          w_commit,
   input  logic          act_valid_i,
   output logic          act_ready_o,
   input  logic [31:0]   act_data_i,
   output logic [31:0]   eng_act_o,
   output logic [511:0]  eng_w_o,
   input  logic [31:0]   eng_res_i,
   output logic          res_valid_o,
   input  logic          res_ready_i,
   output logic [31:0]   res_data_o,
   output logic          busy_o,
`ifdef MAC_CTRL_PERF_EN
   output logic [31:0]   perf_stall_o,
   output logic [31:0]   perf_bp_o,
   output logic [31:0]   perf_swap_o,
`endif
   output logic [15:0]   vec_cnt_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + ENG_LAT + 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_SWAP} state_t;

   state_t                       state_q, state_d;
   logic                         commit_pend_q, commit_pend_d;
   logic [7:0][63:0]             shadow_q, active_q;
   logic [31:0]                  eng_act_q;
   logic [ENG_LAT:0]             tag_q;
   logic [FIFO_DEPTH-1:0][31:0]  fifo_q;
   logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]                fifo_cnt_q, inflight;
   logic [15:0]                  vec_cnt_q;
   logic                         accept, push, pop, swap;

   // Count of vectors between accept and FIFO push (one bit per tag stage)
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= ENG_LAT; i++) inflight = inflight + CW'(tag_q[i]);
   end

   // Only issue when every in-flight vector already owns a FIFO slot
   assign act_ready_o = (state_q == S_RUN) && ((fifo_cnt_q + inflight) < CW'(FIFO_DEPTH));
   assign accept      = act_valid_i && act_ready_o;
   assign push        = tag_q[ENG_LAT];
   assign pop         = res_valid_o && res_ready_i;

   assign eng_act_o   = eng_act_q;
   assign eng_w_o     = active_q;
   assign res_valid_o = (fifo_cnt_q != '0);
   assign res_data_o  = res_valid_o ? fifo_q[rd_ptr_q] : '0;
   assign busy_o      = (state_q != S_IDLE) || (inflight != '0) || (fifo_cnt_q != '0);
   assign vec_cnt_o   = vec_cnt_q;

   // FSM state and sticky commit request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         commit_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         commit_pend_q <= commit_pend_d;
      end
   end

   // Next state: swaps only happen once the engine pipeline is empty
   always_comb begin
      state_d       = state_q;
      commit_pend_d = commit_pend_q;
      swap          = 1'b0;
      case (state_q)
         S_IDLE:  if (w_commit) state_d = S_SWAP;
         S_RUN:   if (w_commit || commit_pend_q) state_d = S_DRAIN;
         S_DRAIN: begin
            if (w_commit) commit_pend_d = 1'b1;
            if (inflight == '0) state_d = S_SWAP;
         end
         S_SWAP: begin
            swap          = 1'b1;
            // a commit landing on the swap cycle is kept for a later swap
            commit_pend_d = w_commit;
            state_d       = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Weight banks; active copies the pre-write shadow on the swap cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (w_wr_en) shadow_q[w_wr_row] <= w_wr_data;
         if (swap)    active_q <= shadow_q;
      end
   end

   // Issue register and in-flight tag shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_act_q <= '0;
         tag_q     <= '0;
      end else begin
         eng_act_q <= accept ? act_data_i : '0;
         tag_q     <= {tag_q[ENG_LAT-1:0], accept};
      end
   end

   // Result FIFO and retired-vector counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         vec_cnt_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= eng_res_i;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
            vec_cnt_q        <= vec_cnt_q + 16'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      end
   end

`ifdef MAC_CTRL_PERF_EN
   logic [31:0] stall_q, bp_q, swapc_q;

   assign perf_stall_o = stall_q;
   assign perf_bp_o    = bp_q;
   assign perf_swap_o  = swapc_q;

   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         bp_q    <= '0;
         swapc_q <= '0;
      end else begin
         if (act_valid_i && !act_ready_o && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (res_valid_o && !res_ready_i && (bp_q != '1))    bp_q    <= bp_q + 32'd1;
         if (((state_q == S_DRAIN) || (state_q == S_SWAP)) && (swapc_q != '1))
            swapc_q <= swapc_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mac_engine_ctrl.sv
// Self-checking bench for mac_engine_ctrl with a 1-cycle mac_engine stand-in
// and a scoreboard fed from a bench-side weight model.
module tb_mac_engine_ctrl;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          w_wr_en = 1'b0;
   logic [2:0]    w_wr_row = '0;
   logic [63:0]   w_wr_data = '0;
   logic          w_commit = 1'b0;
   logic          act_valid_i = 1'b0;
   logic          act_ready_o;
   logic [31:0]   act_data_i = '0;
   logic [31:0]   eng_act_o;
   logic [511:0]  eng_w_o;
   logic [31:0]   eng_res_i = '0;
   logic          res_valid_o;
   logic          res_ready_i = 1'b0;
   logic [31:0]   res_data_o;
   logic          busy_o;
   logic [15:0]   vec_cnt_o;
`ifdef MAC_CTRL_PERF_EN
   logic [31:0]   perf_stall_o, perf_bp_o, perf_swap_o;
`endif

   mac_engine_ctrl #(.ENG_LAT(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .w_wr_en(w_wr_en), .w_wr_row(w_wr_row), .w_wr_data(w_wr_data), .w_commit(w_commit),
      .act_valid_i(act_valid_i), .act_ready_o(act_ready_o), .act_data_i(act_data_i),
      .eng_act_o(eng_act_o), .eng_w_o(eng_w_o), .eng_res_i(eng_res_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .busy_o(busy_o),
`ifdef MAC_CTRL_PERF_EN
      .perf_stall_o(perf_stall_o), .perf_bp_o(perf_bp_o), .perf_swap_o(perf_swap_o),
`endif
      .vec_cnt_o(vec_cnt_o)
   );

   always #5 clk = ~clk;

   int            n_chk = 0, n_fail = 0;
   int            cyc = 0;
   logic [31:0]   sb[$];
   logic [511:0]  tb_shadow = '0, exp_active = '0;
   int            n_res = 0, first_acc = -1, first_res = -1, last_res = -1;

   // 8 results of 4b: res[j] = sum_i act[i]*w[i][j], truncated
   function automatic logic [31:0] mac(input logic [31:0] a, input logic [511:0] w);
      logic [31:0] r;
      logic [15:0] s;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         s = '0;
         for (int i = 0; i < 8; i++) s = s + 16'(a[i*4 +: 4]) * 16'(w[i*64 + j*8 +: 8]);
         r[j*4 +: 4] = s[3:0];
      end
      return r;
   endfunction

   // mac_engine stand-in, latency 1
   always @(posedge clk) eng_res_i <= mac(eng_act_o, eng_w_o);

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push on accept, pop on result handshake; track weight model
   always @(negedge clk) begin
      if (!rst) begin
         if (act_valid_i && act_ready_o) begin
            sb.push_back(mac(act_data_i, exp_active));
            if (first_acc < 0) first_acc = cyc + 1;
         end
         if (res_valid_o && res_ready_i) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_extra: got %h with nothing expected", res_data_o);
            end else begin
               logic [31:0] e;
               e = sb.pop_front();
               if (res_data_o !== e) begin
                  n_fail++;
                  $display("FAIL sb_data: got %h expected %h", res_data_o, e);
               end
            end
            n_res++;
            if (first_res < 0) first_res = cyc;
            last_res = cyc;
         end
         if (w_wr_en) tb_shadow[int'(w_wr_row)*64 +: 64] = w_wr_data;
         if (w_commit) exp_active = tb_shadow;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_row(input int row, input logic [63:0] d);
      w_wr_en = 1'b1; w_wr_row = 3'(row); w_wr_data = d;
      tick();
      w_wr_en = 1'b0;
   endtask

   task automatic commit_pulse();
      w_commit = 1'b1;
      tick();
      w_commit = 1'b0;
   endtask

   task automatic clear_models();
      sb.delete();
      tb_shadow = '0; exp_active = '0;
   endtask

   task automatic send_vecs(input int n, input int commit_at, output int stalls);
      int sent, guard;
      logic acc, done_c;
      sent = 0; guard = 0; stalls = 0; done_c = 1'b0;
      act_valid_i = 1'b1; act_data_i = $urandom;
      while (sent < n && guard < 2000) begin
         if (sent == commit_at && !done_c) begin w_commit = 1'b1; done_c = 1'b1; end
         @(negedge clk);
         acc = act_ready_o;
         if (!acc) stalls++;
         tick();
         w_commit = 1'b0;
         guard++;
         if (acc) begin sent++; act_data_i = $urandom; end
      end
      act_valid_i = 1'b0;
      n_chk++;
      if (sent != n) begin n_fail++; $display("FAIL send_timeout: sent %0d need %0d", sent, n); end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((sb.size() != 0 || res_valid_o) && g < 200) begin tick(); g++; end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL drain_timeout: %0d results missing", sb.size()); end
   endtask

   task automatic test_reset();
      int st;
      #2;
      n_chk++;
      if ({act_ready_o, res_valid_o, busy_o} !== 3'b000 || vec_cnt_o !== 16'd0 ||
          eng_w_o !== '0 || eng_act_o !== '0 || res_data_o !== '0) begin
         n_fail++; $display("FAIL reset_init: ready/valid/busy=%b vec=%0d", {act_ready_o, res_valid_o, busy_o}, vec_cnt_o);
      end
      tick(); rst = 1'b0; clear_models();
      for (int i = 0; i < 8; i++) load_row(i, 64'(1) << (i*8));
      commit_pulse(); tick();
      res_ready_i = 1'b0;
      send_vecs(3, -1, st);
      // three vectors in flight / queued, reset lands mid-stream
      rst = 1'b1; #1;
      n_chk++;
      if ({act_ready_o, res_valid_o, busy_o} !== 3'b000 || vec_cnt_o !== 16'd0 ||
          eng_w_o !== '0 || eng_act_o !== '0 || res_data_o !== '0) begin
         n_fail++; $display("FAIL reset_mid: ready/valid/busy=%b vec=%0d w_zero=%0b", {act_ready_o, res_valid_o, busy_o}, vec_cnt_o, eng_w_o == '0);
      end
      clear_models();
      tick(); rst = 1'b0;
      act_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_chk++;
         if (act_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: ready=%b busy=%b expected 0 0", act_ready_o, busy_o);
         end
         tick();
      end
      act_valid_i = 1'b0;
   endtask

   task automatic test_stream();
      int st;
      for (int i = 0; i < 8; i++) load_row(i, 64'(1) << (i*8));
      commit_pulse(); tick(); tick();
      res_ready_i = 1'b1;
      n_res = 0; first_acc = -1; first_res = -1; last_res = -1;
      send_vecs(50, -1, st);
      wait_drain();
      n_chk++;
      if (n_res != 50) begin n_fail++; $display("FAIL stream_count: got %0d expected 50", n_res); end
      n_chk++;
      if (first_res - first_acc != 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first_res - first_acc); end
      n_chk++;
      if (last_res - first_res != 49 || st != 0) begin
         n_fail++; $display("FAIL stream_rate: span %0d stalls %0d expected 49 0", last_res - first_res, st);
      end
      n_chk++;
      if (vec_cnt_o !== 16'd50) begin n_fail++; $display("FAIL stream_veccnt: got %0d expected 50", vec_cnt_o); end
   endtask

   task automatic test_backpressure();
      int acc_cnt, st, r0;
      r0 = n_res; acc_cnt = 0;
      res_ready_i = 1'b0; act_valid_i = 1'b1; act_data_i = $urandom;
      for (int k = 0; k < 10; k++) begin
         logic a;
         @(negedge clk);
         a = act_ready_o;
         if (a) acc_cnt++;
         tick();
         if (a) act_data_i = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (acc_cnt != 4 || act_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL bp_credit: accepted %0d ready=%b expected 4 0", acc_cnt, act_ready_o);
      end
      tick();
      res_ready_i = 1'b1;
      send_vecs(8, -1, st);
      wait_drain();
      n_chk++;
      if (n_res - r0 != 12 || vec_cnt_o !== 16'd62) begin
         n_fail++; $display("FAIL bp_total: results %0d vec %0d expected 12 62", n_res - r0, vec_cnt_o);
      end
   endtask

   task automatic test_commit_midstream();
      int st;
      for (int i = 0; i < 8; i++) load_row(i, {$urandom, $urandom});
      res_ready_i = 1'b1;
      // commit with two vectors in the engine: 3 drain cycles + 1 swap cycle
      send_vecs(10, 4, st);
      n_chk++;
      if (st != 4) begin n_fail++; $display("FAIL commit_stall: got %0d expected 4", st); end
      wait_drain();
      n_chk++;
      if (eng_w_o !== exp_active) begin n_fail++; $display("FAIL commit_bank: active bank differs from new weights"); end
   endtask

   task automatic test_commit_in_drain();
      int st;
      logic [63:0] x, y;
      logic [3:0] rdy;
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      res_ready_i = 1'b1;
      load_row(0, x);
      w_commit = 1'b1; @(negedge clk); rdy[0] = act_ready_o; tick();
      w_commit = 1'b1; @(negedge clk); rdy[1] = act_ready_o; tick();
      w_commit = 1'b0;
      w_wr_en = 1'b1; w_wr_row = 3'd5; w_wr_data = y;
      @(negedge clk); rdy[2] = act_ready_o; tick();
      w_wr_en = 1'b0;
      @(negedge clk); rdy[3] = act_ready_o; tick();
      @(negedge clk);
      n_chk++;
      if (rdy !== 4'b1001 || act_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL drain_commit_seq: ready %b,%b expected 1001,1", rdy, act_ready_o);
      end
      n_chk++;
      if (eng_w_o !== exp_active || eng_w_o[5*64 +: 64] === y) begin
         n_fail++; $display("FAIL swap_write: row5 %h must not be %h", eng_w_o[5*64 +: 64], y);
      end
      tick();
      send_vecs(6, -1, st);
      wait_drain();
      commit_pulse(); tick(); tick(); tick();
      n_chk++;
      if (eng_w_o[5*64 +: 64] !== y) begin
         n_fail++; $display("FAIL swap_write_next: row5 %h expected %h", eng_w_o[5*64 +: 64], y);
      end
      send_vecs(6, -1, st);
      wait_drain();
   endtask

`ifdef MAC_CTRL_PERF_EN
   task automatic test_perf();
      rst = 1'b1; #1;
      n_chk++;
      if (perf_stall_o !== 0 || perf_bp_o !== 0 || perf_swap_o !== 0) begin
         n_fail++; $display("FAIL perf_reset: %0d %0d %0d expected 0 0 0", perf_stall_o, perf_bp_o, perf_swap_o);
      end
      clear_models();
      tick(); rst = 1'b0;
      res_ready_i = 1'b1;
      commit_pulse(); tick();
      res_ready_i = 1'b0; act_valid_i = 1'b1; act_data_i = $urandom;
      for (int k = 0; k < 10; k++) begin
         logic a;
         @(negedge clk);
         a = act_ready_o;
         tick();
         if (a) act_data_i = $urandom;
      end
      act_valid_i = 1'b0;
      n_chk++;
      if (perf_stall_o !== 32'd6 || perf_bp_o !== 32'd7 || perf_swap_o !== 32'd1) begin
         n_fail++; $display("FAIL perf_counts: stall %0d bp %0d swap %0d expected 6 7 1", perf_stall_o, perf_bp_o, perf_swap_o);
      end
      res_ready_i = 1'b1;
      wait_drain();
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_commit_midstream();
      test_commit_in_drain();
`ifdef MAC_CTRL_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
